// File: rtl/proc_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// proc_issue_ctrl_if
// Host-side instruction handshake into the issue controller's queue.
//   InstrValid : host offers InstrData this cycle
//   InstrData  : 9-bit instruction word (opcode III XXX YYY or mvi immediate)
//   InstrReady : queue can take a word; a push happens on
//                InstrValid & InstrReady at the rising clock edge
// The master modport is the host side. The slave modport is the controller side.
// ---------------------------------------------------------------------------
interface proc_issue_ctrl_if;
  logic       InstrValid;
  logic [8:0] InstrData;
  logic       InstrReady;

  modport master (output InstrValid, output InstrData, input InstrReady);
  modport slave  (input InstrValid, input InstrData, output InstrReady);
endinterface

// File: rtl/proc_issue_ctrl.sv
// ---------------------------------------------------------------------------
// proc_issue_ctrl
// Buffers host instruction words in a 4-deep queue and issues them one at a
// time to a simple processor through a DIN/Run/Done handshake.
//
// Ports
//   Clock      : system clock, all state on the rising edge
//   Reset      : synchronous, active-high
//   host       : instruction push handshake (InstrValid/InstrData/InstrReady)
//   Halt       : blocks new issues; an in-flight instruction still completes
//   ErrClr     : clears the sticky Error flag
//   DIN        : registered word presented to the processor
//   Run        : registered one-cycle start pulse
//   Done       : processor completion flag, only looked at while waiting
//   Busy       : an instruction is in flight or the queue is non-empty
//   IssueCount : completed instructions, wraps 255 -> 0
//   Error      : sticky flag, set when Done fails to arrive in time
//
// An mvi opcode (DIN[8:6] = 001) carries its immediate in the next queue
// entry. It is only issued once both words are queued, so the immediate is
// always present when the controller pops it one cycle after the opcode.
// ---------------------------------------------------------------------------
module proc_issue_ctrl (
  input  logic                   Clock,
  input  logic                   Reset,
  proc_issue_ctrl_if.slave       host,
  input  logic                   Halt,
  input  logic                   ErrClr,
  input  logic                   Done,
  output logic [8:0]             DIN,
  output logic                   Run,
  output logic                   Busy,
  output logic [7:0]             IssueCount,
  output logic                   Error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [2:0] OP_MVI   = 3'b001;
  // The counter holds the number of Done=0 wait cycles already seen, so the
  // 15th such cycle is the one that starts with the counter at 14.
  localparam logic [3:0] TMO_LAST = 4'd14;

  // ---------------- queue ----------------
  logic [8:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;

  logic       full, empty, ready, push, pop;
  logic [8:0] head;
  logic       head_is_mvi;

  assign full        = (count_q == 3'd4);
  assign empty       = (count_q == 3'd0);
  assign head        = fifo_q[rd_ptr_q];
  assign head_is_mvi = (head[8:6] == OP_MVI);

  // Ready drops combinationally with Reset so nothing is accepted while the
  // queue is being cleared.
  assign ready           = !full && !Reset;
  assign host.InstrReady = ready;
  assign push            = host.InstrValid && ready;

  // ---------------- control ----------------
  state_e     state_q, state_d;
  logic [8:0] din_q, din_d;
  logic       run_q, run_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [3:0] tmo_q, tmo_d;
  logic       mvi_q, mvi_d;

  // NOTE: every signal gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    run_d   = 1'b0;
    cnt_d   = cnt_q;
    err_d   = ErrClr ? 1'b0 : err_q;
    tmo_d   = tmo_q;
    mvi_d   = mvi_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An mvi at the head waits until its immediate is queued behind it.
        if (!Halt && !empty && (!head_is_mvi || count_q >= 3'd2)) begin
          pop     = 1'b1;
          din_d   = head;
          run_d   = 1'b1;
          mvi_d   = head_is_mvi;
          tmo_d   = 4'd0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        if (mvi_q) begin
          pop   = 1'b1;
          din_d = head;
        end else begin
          din_d = 9'd0;
        end
      end

      S_WAIT: begin
        if (Done) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 8'd1;
          din_d   = 9'd0;
          tmo_d   = 4'd0;
        end else if (tmo_q == TMO_LAST) begin
          // Setting Error here overrides a same-cycle ErrClr.
          err_d   = 1'b1;
          state_d = S_IDLE;
          din_d   = 9'd0;
          tmo_d   = 4'd0;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Push and pop in the same cycle cancel out in the count.
  assign count_d = count_q + {2'b00, push} - {2'b00, pop};

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      din_q    <= 9'd0;
      run_q    <= 1'b0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      tmo_q    <= 4'd0;
      mvi_q    <= 1'b0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      mvi_q   <= mvi_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  // NOTE: the queue storage has no reset; the pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge Clock) begin
    if (push) fifo_q[wr_ptr_q] <= host.InstrData;
  end

  assign DIN        = din_q;
  assign Run        = run_q;
  assign IssueCount = cnt_q;
  assign Error      = err_q;
  assign Busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_proc_issue_ctrl.sv
module tb_proc_issue_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Halt, ErrClr, Done;
  logic [8:0] DIN;
  logic       Run, Busy, Error;
  logic [7:0] IssueCount;

  proc_issue_ctrl_if host_if ();

  proc_issue_ctrl dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .host       (host_if),
    .Halt       (Halt),
    .ErrClr     (ErrClr),
    .Done       (Done),
    .DIN        (DIN),
    .Run        (Run),
    .Busy       (Busy),
    .IssueCount (IssueCount),
    .Error      (Error)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // Transaction view: a queue of words plus "how long since Run" for the
  // instruction currently in flight.
  logic [8:0] mq [$];
  bit         m_inflight;
  int         m_age;       // 0 = the Run cycle, 1 = waiting for Done
  int         m_lows;      // Done=0 cycles seen while waiting
  bit         m_mvi;
  logic       m_run;
  logic [8:0] m_din;
  logic [7:0] m_cnt;
  logic       m_err;

  task automatic model_step();
    bit can_push;
    if (Reset) begin
      mq.delete();
      m_inflight = 0; m_age = 0; m_lows = 0; m_mvi = 0;
      m_run = 1'b0; m_din = 9'd0; m_cnt = 8'd0; m_err = 1'b0;
    end else begin
      can_push = (mq.size() < 4);
      m_run = 1'b0;
      if (ErrClr) m_err = 1'b0;
      if (!m_inflight) begin
        if (!Halt && mq.size() > 0 &&
            (mq[0][8:6] != 3'b001 || mq.size() >= 2)) begin
          m_din      = mq.pop_front();
          m_mvi      = (m_din[8:6] == 3'b001);
          m_run      = 1'b1;
          m_inflight = 1;
          m_age      = 0;
          m_lows     = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
        m_din = m_mvi ? mq.pop_front() : 9'd0;
      end else if (Done) begin
        m_cnt      = m_cnt + 8'd1;
        m_din      = 9'd0;
        m_inflight = 0;
      end else begin
        m_lows++;
        if (m_lows == 15) begin
          m_err      = 1'b1;
          m_din      = 9'd0;
          m_inflight = 0;
        end
      end
      if (host_if.InstrValid && can_push) mq.push_back(host_if.InstrData);
    end
  endtask

  // One clock: the model follows the edge, outputs are then sampled on the
  // falling edge.
  task automatic tick();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    host_if.InstrValid = 1'b0;
    host_if.InstrData  = 9'd0;
    Halt = 1'b0; ErrClr = 1'b0; Done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    n_checks++; if (Run !== 1'b0) $display("FAIL reset_run got=%0h exp=0", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h000) $display("FAIL reset_din got=%0h exp=0", DIN); else n_pass++;
    n_checks++; if (IssueCount !== 8'd0) $display("FAIL reset_cnt got=%0h exp=0", IssueCount); else n_pass++;
    n_checks++; if (Error !== 1'b0) $display("FAIL reset_err got=%0h exp=0", Error); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", Busy); else n_pass++;
    n_checks++; if (host_if.InstrReady !== 1'b0) $display("FAIL reset_ready_in_reset got=%0h exp=0", host_if.InstrReady); else n_pass++;
    Reset = 1'b0;
    #1;
    n_checks++; if (host_if.InstrReady !== 1'b1) $display("FAIL reset_ready_after got=%0h exp=1", host_if.InstrReady); else n_pass++;
  endtask

  task automatic test_mv();
    do_reset();
    host_if.InstrValid = 1'b1; host_if.InstrData = 9'h020;
    tick();
    host_if.InstrValid = 1'b0;
    n_checks++; if (Run !== 1'b0) $display("FAIL mv_latency_run got=%0h exp=0", Run); else n_pass++;
    n_checks++; if (Busy !== 1'b1) $display("FAIL mv_busy got=%0h exp=1", Busy); else n_pass++;
    tick();
    n_checks++; if (Run !== 1'b1) $display("FAIL mv_run got=%0h exp=1", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h020) $display("FAIL mv_din got=%0h exp=020", DIN); else n_pass++;
    tick();
    n_checks++; if (Run !== 1'b0) $display("FAIL mv_run_drop got=%0h exp=0", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h000) $display("FAIL mv_din_zero got=%0h exp=000", DIN); else n_pass++;
    tick();
    tick();
    Done = 1'b1;          // Done high three cycles after the Run cycle
    tick();
    Done = 1'b0;
    n_checks++; if (IssueCount !== 8'd1) $display("FAIL mv_cnt got=%0h exp=1", IssueCount); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL mv_busy_end got=%0h exp=0", Busy); else n_pass++;
  endtask

  task automatic test_mvi();
    do_reset();
    host_if.InstrValid = 1'b1; host_if.InstrData = 9'h040;
    tick();
    host_if.InstrData = 9'h007;
    tick();
    host_if.InstrValid = 1'b0;
    n_checks++; if (Run !== 1'b0) $display("FAIL mvi_wait_run got=%0h exp=0", Run); else n_pass++;
    tick();
    n_checks++; if (Run !== 1'b1) $display("FAIL mvi_run got=%0h exp=1", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h040) $display("FAIL mvi_din_op got=%0h exp=040", DIN); else n_pass++;
    tick();
    n_checks++; if (DIN !== 9'h007) $display("FAIL mvi_din_imm got=%0h exp=007", DIN); else n_pass++;
    Done = 1'b1;
    tick();
    Done = 1'b0;
    n_checks++; if (IssueCount !== 8'd1) $display("FAIL mvi_cnt got=%0h exp=1", IssueCount); else n_pass++;
    n_checks++; if (DIN !== 9'h000) $display("FAIL mvi_din_done got=%0h exp=000", DIN); else n_pass++;
  endtask

  task automatic test_mvi_stall();
    int runs;
    do_reset();
    host_if.InstrValid = 1'b1; host_if.InstrData = 9'h048;
    tick();
    host_if.InstrValid = 1'b0;
    runs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Run === 1'b1) runs++;
    end
    n_checks++; if (runs != 0) $display("FAIL stall_run_pulses got=%0d exp=0", runs); else n_pass++;
    host_if.InstrValid = 1'b1; host_if.InstrData = 9'h009;
    tick();
    host_if.InstrValid = 1'b0;
    n_checks++; if (Run !== 1'b0) $display("FAIL stall_latency got=%0h exp=0", Run); else n_pass++;
    tick();
    n_checks++; if (Run !== 1'b1) $display("FAIL stall_run got=%0h exp=1", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h048) $display("FAIL stall_din_op got=%0h exp=048", DIN); else n_pass++;
    tick();
    n_checks++; if (DIN !== 9'h009) $display("FAIL stall_din_imm got=%0h exp=009", DIN); else n_pass++;
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  task automatic test_full_halt();
    logic [8:0] words [4];
    bit found;
    int extra;
    words[0] = 9'h0C1; words[1] = 9'h020; words[2] = 9'h0D1; words[3] = 9'h020;
    do_reset();
    Halt = 1'b1;
    host_if.InstrValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_if.InstrData = words[i];
      tick();
    end
    n_checks++; if (host_if.InstrReady !== 1'b0) $display("FAIL full_ready got=%0h exp=0", host_if.InstrReady); else n_pass++;
    host_if.InstrData = 9'h1FF;         // fifth push must be dropped
    tick();
    host_if.InstrValid = 1'b0;
    n_checks++; if (Run !== 1'b0) $display("FAIL halt_run got=%0h exp=0", Run); else n_pass++;
    Halt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int t = 0; t < 8 && !found; t++) begin
        tick();
        if (Run === 1'b1) found = 1;
      end
      n_checks++; if (!found) $display("FAIL full_issue%0d_run got=0 exp=1", k); else n_pass++;
      n_checks++; if (DIN !== words[k]) $display("FAIL full_issue%0d_din got=%0h exp=%0h", k, DIN, words[k]); else n_pass++;
      tick();
      Done = 1'b1;
      tick();
      Done = 1'b0;
    end
    n_checks++; if (IssueCount !== 8'd4) $display("FAIL full_cnt got=%0d exp=4", IssueCount); else n_pass++;
    extra = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (Run === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL full_fifth_issued got=%0d exp=0", extra); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL full_busy_end got=%0h exp=0", Busy); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    host_if.InstrValid = 1'b1; host_if.InstrData = 9'h10A;
    tick();
    host_if.InstrValid = 1'b0;
    tick();
    n_checks++; if (Run !== 1'b1) $display("FAIL tmo_run got=%0h exp=1", Run); else n_pass++;
    tick();                             // first WAIT cycle
    for (int i = 0; i < 14; i++) tick();
    n_checks++; if (Error !== 1'b0) $display("FAIL tmo_early got=%0h exp=0", Error); else n_pass++;
    n_checks++; if (Busy !== 1'b1) $display("FAIL tmo_busy_wait got=%0h exp=1", Busy); else n_pass++;
    tick();
    n_checks++; if (Error !== 1'b1) $display("FAIL tmo_err got=%0h exp=1", Error); else n_pass++;
    n_checks++; if (IssueCount !== 8'd0) $display("FAIL tmo_cnt got=%0d exp=0", IssueCount); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL tmo_busy got=%0h exp=0", Busy); else n_pass++;
    tick();
    n_checks++; if (Error !== 1'b1) $display("FAIL tmo_sticky got=%0h exp=1", Error); else n_pass++;
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    n_checks++; if (Error !== 1'b0) $display("FAIL tmo_clr got=%0h exp=0", Error); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int runs;
    do_reset();
    host_if.InstrValid = 1'b1;
    host_if.InstrData = 9'h0C1; tick();
    host_if.InstrData = 9'h020; tick();   // 0x0C1 issues on this edge
    host_if.InstrData = 9'h030; tick();   // now waiting, two words queued
    host_if.InstrValid = 1'b0;
    n_checks++; if (Busy !== 1'b1) $display("FAIL rmid_busy_pre got=%0h exp=1", Busy); else n_pass++;
    Reset = 1'b1;
    tick();
    n_checks++; if (Run !== 1'b0) $display("FAIL rmid_run got=%0h exp=0", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h000) $display("FAIL rmid_din got=%0h exp=0", DIN); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL rmid_busy got=%0h exp=0", Busy); else n_pass++;
    n_checks++; if (IssueCount !== 8'd0) $display("FAIL rmid_cnt got=%0d exp=0", IssueCount); else n_pass++;
    Reset = 1'b0;
    Done = 1'b1;                          // a late Done must not count
    runs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Run === 1'b1) runs++;
    end
    Done = 1'b0;
    n_checks++; if (runs != 0) $display("FAIL rmid_queue_flushed got=%0d exp=0", runs); else n_pass++;
    n_checks++; if (IssueCount !== 8'd0) $display("FAIL rmid_cnt_late got=%0d exp=0", IssueCount); else n_pass++;
  endtask

  task automatic test_random();
    int   done_pct;
    logic prev_run;
    bit   m_busy, m_ready;
    do_reset();
    prev_run = 1'b0;
    done_pct = 30;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        case ($urandom_range(2))
          0:       done_pct = 0;
          1:       done_pct = 25;
          default: done_pct = 70;
        endcase
      end
      Reset              = ($urandom_range(299) == 0);
      host_if.InstrValid = ($urandom_range(1) == 1);
      if ($urandom_range(3) == 0) host_if.InstrData = {3'b001, 6'($urandom)};
      else                        host_if.InstrData = 9'($urandom);
      Halt   = ($urandom_range(9) == 0);
      Done   = ($urandom_range(99) < done_pct);
      ErrClr = ($urandom_range(19) == 0);
      tick();
      m_busy  = m_inflight || (mq.size() > 0);
      m_ready = !Reset && (mq.size() < 4);
      n_checks++; if (Run !== m_run) $display("FAIL rnd_run c=%0d got=%0h exp=%0h", c, Run, m_run); else n_pass++;
      n_checks++; if (DIN !== m_din) $display("FAIL rnd_din c=%0d got=%0h exp=%0h", c, DIN, m_din); else n_pass++;
      n_checks++; if (IssueCount !== m_cnt) $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, IssueCount, m_cnt); else n_pass++;
      n_checks++; if (Error !== m_err) $display("FAIL rnd_err c=%0d got=%0h exp=%0h", c, Error, m_err); else n_pass++;
      n_checks++; if (Busy !== m_busy) $display("FAIL rnd_busy c=%0d got=%0h exp=%0h", c, Busy, m_busy); else n_pass++;
      n_checks++; if (host_if.InstrReady !== m_ready) $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, host_if.InstrReady, m_ready); else n_pass++;
      n_checks++; if (Run === 1'b1 && prev_run === 1'b1) $display("FAIL rnd_run_twice c=%0d got=11 exp=not 11", c); else n_pass++;
      prev_run = Run;
    end
    idle_inputs();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_mv();
    test_mvi();
    test_mvi_stall();
    test_full_halt();
    test_timeout();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/proc_issue_ctrl.md
PROC_ISSUE_CTRL -- requirements
Module: proc_issue_ctrl

Interface
REQ-001 SHALL use one clock and synchronous active-high reset: ports Clock and Reset.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high; sampled on rising edge of Clock.
REQ-004 InstrValid  input  1  host offers InstrData this cycle.
REQ-005 InstrData  input  9  host word: opcode III XXX YYY, or a mvi immediate.
REQ-006 InstrReady  output  1  queue can accept a word; push = InstrValid & InstrReady at rising edge.
REQ-007 Halt  input  1  when 1, no new instruction issues; an in-flight instruction completes.
REQ-008 ErrClr  input  1  clears Error.
REQ-009 DIN  output  9  registered word driven to processor DIN.
REQ-010 Run  output  1  registered one-cycle start pulse to processor.
REQ-011 Done  input  1  processor completion flag.
REQ-012 Busy  output  1  state != IDLE or queue non-empty.
REQ-013 IssueCount  output  8  completed instructions, wraps 255->0.
REQ-014 Error  output  1  sticky Done-timeout flag.

Function
REQ-015 SHALL hold a 4-entry, 9-bit FIFO; InstrReady = !full & !Reset; a push when full is ignored; no write-through bypass.
REQ-016 Opcode field DIN[8:6]=001 (mvi) SHALL be two-word: opcode entry followed by immediate entry; all other opcodes are one-word.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-018 IDLE -> ISSUE when Halt=0, FIFO non-empty, and (head opcode != 001 or FIFO holds >= 2 entries); head opcode popped; DIN<=opcode, Run<=1.
REQ-019 mvi opcode at head with no immediate queued SHALL stall in IDLE with Run=0.
REQ-020 ISSUE -> WAIT unconditionally after one cycle; Run<=0; DIN<=popped immediate for mvi, else DIN<=0.
REQ-021 Word pushed at edge E with empty FIFO and idle FSM SHALL produce Run=1 in the cycle following edge E+1 (one-cycle latency).
REQ-022 WAIT: Done=1 sampled -> IDLE, IssueCount+1, DIN<=0, timeout counter cleared; Done sampled only in WAIT.
REQ-023 4-bit timeout counter SHALL increment each WAIT cycle with Done=0; on 15th such cycle: Error<=1, -> IDLE, IssueCount unchanged.
REQ-024 Next issue SHALL not occur earlier than the cycle after WAIT->IDLE (minimum 1 IDLE cycle between Run pulses).
REQ-025 Simultaneous push and pop SHALL both take effect; FIFO count unchanged.
REQ-026 ErrClr=1 SHALL clear Error; if timeout sets Error same cycle, set wins.
REQ-027 Halt asserted in ISSUE or WAIT SHALL not abort the instruction.
REQ-028 Run SHALL never be high for two consecutive cycles.

Reset
REQ-029 Reset=1 SHALL force: state IDLE, FIFO empty, DIN=0, Run=0, IssueCount=0, Error=0, timeout=0, InstrReady=0, Busy=0 after the edge.
REQ-030 Reset mid-ISSUE or mid-WAIT SHALL abandon the instruction with no IssueCount increment; queued words discarded.
REQ-031 InstrReady SHALL return to 1 in the first cycle Reset=0.

Verification
REQ-032 Push 0x020 (mv R4,R0), Done pulses 3 cycles after Run -> Run=1 one cycle with DIN=0x020, next cycle DIN=0x000, IssueCount=1, Busy=0 after.
REQ-033 Push 0x040 then 0x007 (mvi R0,7) -> Run cycle DIN=0x040, next cycle DIN=0x007, Done -> IssueCount=1.
REQ-034 Push 0x048 only, wait 10 cycles -> Run stays 0; push 0x009 -> Run next-but-one cycle with DIN=0x048, then DIN=0x009.
REQ-035 Halt=1, push 0x0C1,0x020,0x0D1,0x020 -> InstrReady=0 after 4th push, 5th push ignored; Halt=0 -> four issues in FIFO order, IssueCount=4.
REQ-036 Push 0x10A, hold Done=0 -> Error=1 after 15 WAIT cycles, IssueCount=0; ErrClr=1 -> Error=0.
REQ-037 Reset=1 during WAIT of 0x0C1 with 2 words queued -> next cycle Run=0, DIN=0, Busy=0, IssueCount=0, FIFO empty.
